if_fetch_unit: RTL

Instruction-fetch stage that produces `IF_pc`/`IF_inst` for the IF/ID pipeline register. It owns the PC register and issues requests to instruction memory over a req/ack handshake. It honours the same `dpc_control` stall the IF/ID register uses, and takes branch/jump redirects from later stages. Stalled fetches are buffered so no instruction is lost. Redirects flush the output with a NOP bubble.

---
 rtl/if_fetch_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction-memory port and feeds IF/ID.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects raise fetch_misalign and park fetching.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dpc_control,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst,
    output logic        IF_valid,
    output logic        fetch_misalign
);

    typedef enum logic [1:0] {S_BOOT, S_REQ, S_HOLD, S_DISCARD} state_t;

    state_t      r_state, w_state_n;
    logic [31:0] r_pc_q, w_pc_n;
    logic [31:0] r_buf_pc, w_buf_pc_n;
    logic [31:0] r_buf_inst, w_buf_inst_n;
    logic [31:0] r_disc_addr, w_disc_addr_n;
    logic [31:0] r_if_pc, w_if_pc_n;
    logic [31:0] r_if_inst, w_if_inst_n;
    logic        r_if_valid, w_if_valid_n;
    logic        r_misalign, w_misalign_n;
    logic        w_req, w_ack, w_trap;
    logic [31:0] w_redir_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_trap     = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign w_redir_pc = redirect_pc;
`else
    assign w_trap     = 1'b0;
    assign w_redir_pc = redirect_pc & ~32'h0000_0003;
`endif

    // A discarded request keeps presenting its original address until memory acks it.
    assign w_req          = ((r_state == S_REQ) || (r_state == S_DISCARD)) && !r_misalign;
    assign w_ack          = imem_ack && w_req;
    assign imem_req       = w_req;
    assign imem_addr      = (r_state == S_DISCARD) ? r_disc_addr : r_pc_q;
    assign IF_pc          = r_if_pc;
    assign IF_inst        = r_if_inst;
    assign IF_valid       = r_if_valid;
    assign fetch_misalign = r_misalign;

    always_comb begin
        w_state_n     = r_state;
        w_pc_n        = r_pc_q;
        w_buf_pc_n    = r_buf_pc;
        w_buf_inst_n  = r_buf_inst;
        w_disc_addr_n = r_disc_addr;
        w_if_pc_n     = r_if_pc;
        w_if_inst_n   = r_if_inst;
        w_if_valid_n  = r_if_valid;
        w_misalign_n  = r_misalign;

        if (redirect_valid) begin
            w_pc_n       = w_redir_pc;
            w_buf_pc_n   = '0;
            w_buf_inst_n = NOP_INST;
            w_if_inst_n  = NOP_INST;
            w_if_valid_n = 1'b0;
            w_misalign_n = w_trap;
            // An in-flight request must drain before the new target can be fetched.
            if (!w_trap && w_req && !w_ack) begin
                w_state_n = S_DISCARD;
                if (r_state == S_REQ)
                    w_disc_addr_n = r_pc_q;
            end else begin
                w_state_n = S_REQ;
            end
        end else begin
            case (r_state)
                S_BOOT: w_state_n = S_REQ;
                S_REQ: begin
                    if (w_ack) begin
                        w_pc_n = r_pc_q + 32'd4;
                        if (dpc_control) begin
                            w_buf_pc_n   = r_pc_q;
                            w_buf_inst_n = imem_rdata;
                            w_state_n    = S_HOLD;
                        end else begin
                            w_if_pc_n    = r_pc_q;
                            w_if_inst_n  = imem_rdata;
                            w_if_valid_n = 1'b1;
                        end
                    end else if (!dpc_control) begin
                        w_if_inst_n  = NOP_INST;
                        w_if_valid_n = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!dpc_control) begin
                        w_if_pc_n    = r_buf_pc;
                        w_if_inst_n  = r_buf_inst;
                        w_if_valid_n = 1'b1;
                        w_state_n    = S_REQ;
                    end
                end
                default: begin
                    w_if_inst_n  = NOP_INST;
                    w_if_valid_n = 1'b0;
                    if (w_ack)
                        w_state_n = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_BOOT;
            r_pc_q     <= RESET_PC;
            r_if_pc    <= '0;
            r_if_inst  <= NOP_INST;
            r_if_valid <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_pc_q     <= w_pc_n;
            r_if_pc    <= w_if_pc_n;
            r_if_inst  <= w_if_inst_n;
            r_if_valid <= w_if_valid_n;
            r_misalign <= w_misalign_n;
        end
    end

    // Hold buffer and discard address are only read in states that load them first.
    always_ff @(posedge clk) begin
        r_buf_pc    <= w_buf_pc_n;
        r_buf_inst  <= w_buf_inst_n;
        r_disc_addr <= w_disc_addr_n;
    end

endmodule
